// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_reg_* elastic pipeline family.
// Combinational only: no latency and no backpressure of its own.
// Backpressure: not applicable; consumers size their counters with clog2_occ.
package pipe_pkg;

  localparam logic RST_VALUE_DEFAULT = 1'b0;

  // Width of a counter that must hold every value from 0 up to the chain capacity.
  function automatic int clog2_occ(input int depth, input bit skid);
    return $clog2((skid ? 2 * depth : depth) + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One elastic pipeline stage; PIPE_REG_CHAIN_SKID_EN adds a skid register and a flopped up_ready.
// Latency: 1 cycle from up-side handshake to dn_valid.
// Backpressure: holds dn_valid/dn_data until dn_ready; without skid up_ready is combinational from dn_ready.
module pipe_reg_stage
  import pipe_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic RST_VALUE  = RST_VALUE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [DATA_WIDTH-1:0] dn_data
);

  localparam logic [DATA_WIDTH-1:0] RST_DATA = {DATA_WIDTH{RST_VALUE}};

  logic                  valid;
  logic [DATA_WIDTH-1:0] data;

  assign dn_valid = valid;
  assign dn_data  = data;

`ifdef PIPE_REG_CHAIN_SKID_EN
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  main_free;

  // skid_valid is a flop, so up_ready never sees a combinational path from downstream.
  assign up_ready  = ~skid_valid;
  assign main_free = ~valid | dn_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid      <= 1'b0;
      data       <= RST_DATA;
      skid_valid <= 1'b0;
      skid_data  <= RST_DATA;
    end else if (skid_valid) begin
      // Main register is necessarily full here; the skid entry moves up once it drains.
      if (main_free) begin
        data       <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= RST_DATA;
      end
    end else if (main_free) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end else if (up_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= up_data;
    end
  end
`else
  assign up_ready = ~valid | dn_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      data  <= RST_DATA;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end
`endif

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH elastic stages with valid/ready on both ends plus an occupancy count; PIPE_REG_CHAIN_SKID_EN doubles capacity.
// Latency: DEPTH cycles from input handshake to output handshake when unstalled.
// Backpressure: stalls propagate stage by stage; in_ready is forced low during rst.
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   DEPTH      = 2,
  parameter logic RST_VALUE  = RST_VALUE_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic [clog2_occ(DEPTH, 1'b1)-1:0]   occupancy
);

  localparam int OCC_W = clog2_occ(DEPTH, 1'b1);

  logic in_fire;
  logic out_fire;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                  up_valid;
    logic                  up_ready;
    logic [DATA_WIDTH-1:0] up_data;
    logic                  dn_valid;
    logic                  dn_ready;
    logic [DATA_WIDTH-1:0] dn_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = g_stage[k-1].dn_valid;
      assign up_data  = g_stage[k-1].dn_data;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_inner
      assign dn_ready = g_stage[k+1].up_ready;
    end

    pipe_reg_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST_VALUE  (RST_VALUE)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_valid),
      .up_ready (up_ready),
      .up_data  (up_data),
      .dn_valid (dn_valid),
      .dn_ready (dn_ready),
      .dn_data  (dn_data)
    );
  end

  assign in_ready  = g_stage[0].up_ready & ~rst;
  assign out_valid = g_stage[DEPTH-1].dn_valid;
  assign out_data  = g_stage[DEPTH-1].dn_data;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A flush empties every stage, so the count restarts at zero whatever fired that cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) occupancy <= '0;
    else              occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: directed streaming/backpressure/flush/reset phases then random traffic.
// The reference model is an ordered queue of accepted beats tagged with their accept edge.
module tb_pipe_reg_chain;

`ifdef PIPE_REG_CHAIN_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 3;
`endif
  localparam int OW = $clog2(2 * DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic [OW-1:0] occupancy;

  typedef struct {
    logic [7:0] d;
    int         e;
  } beat_t;

  beat_t      sb[$];
  beat_t      b;
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         n_out = 0;
  int         max_occ = 0;
  int         n0;
  int         nacc;
  bit         mon_en = 1'b0;
  bit         lat_chk = 1'b0;
  bit         stalled = 1'b0;
  logic       last_acc;
  logic [7:0] held;

  pipe_reg_chain #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .RST_VALUE  (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: drive at negedge, sample handshake just after, update the model after the edge.
  task automatic step(input logic iv, input logic [7:0] id, input logic ordy,
                      input logic fl, input logic rs);
    logic acc;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl; rst = rs;
    #1;
    if (rs) check("in_ready_in_rst", 32'(in_ready), 32'd0);
`ifndef PIPE_REG_CHAIN_SKID_EN
    else check("in_ready", 32'(in_ready), 32'((sb.size() < DEPTH) || ordy));
`endif
    acc = iv && in_ready;
    last_acc = acc;
    @(posedge clk); #1;
    if (rs || fl) sb.delete();
    else if (acc) sb.push_back('{d: id, e: cyc});
  endtask

  // Monitor: compares every delivered beat and the occupancy against the model.
  initial forever begin
    @(negedge clk); #2;
    if (mon_en) begin
      check("occupancy", 32'(occupancy), 32'(sb.size()));
      if (stalled) begin
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_data", 32'(out_data), 32'(held));
      end
      if (lat_chk && int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (out_valid && out_ready && !rst) begin
        n_out++;
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat (cycle %0d)", out_data, cyc);
        end else begin
          b = sb.pop_front();
          check("out_data", 32'(out_data), 32'(b.d));
          if (lat_chk) check("latency", 32'(cyc + 1 - b.e), 32'(DEPTH));
        end
      end
      stalled = out_valid && !out_ready && !flush && !rst;
      held = out_data;
    end
  end

  initial begin
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_occupancy", 32'(occupancy), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_data", 32'(out_data), 32'h00);
    mon_en = 1'b1;

    // Back-to-back streaming with the sink always ready.
    lat_chk = 1'b1; max_occ = 0; n0 = n_out;
    for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    repeat (DEPTH + 3) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    lat_chk = 1'b0;
    check("stream_peak_occ", 32'(max_occ), 32'(DEPTH));
    check("stream_beats", 32'(n_out - n0), 32'd10);

    // Backpressure: tail must hold 0xA0 while stalled.
    n0 = n_out;
    for (int i = 0; i < 3; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'hA0);
`ifndef PIPE_REG_CHAIN_SKID_EN
      check("bp_in_ready", 32'(in_ready), 32'd0);
`endif
    end
    repeat (8) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("bp_drained", 32'(n_out - n0), 32'd3);

    // Flush while full with a beat offered on the input.
    for (int i = 0; i < 3; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    check("flush_occupancy", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data", 32'(out_data), 32'h00);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with two beats held.
    step(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_occupancy", 32'(occupancy), 32'd2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_REG_CHAIN_SKID_EN
    // Skid capacity: four beats fit into two stages while the sink stalls.
    nacc = 0; n0 = n_out;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0);
      nacc += int'(last_acc);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("skid_accepts", 32'(nacc), 32'd4);
    check("skid_occupancy", 32'(occupancy), 32'd4);
    check("skid_in_ready", 32'(in_ready), 32'd0);
    repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("skid_drained", 32'(n_out - n0), 32'd4);
`endif

    // Random traffic with occasional flushes.
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(3) != 0), 8'($urandom), 1'($urandom_range(2) != 0),
           1'($urandom_range(99) == 0), 1'b0);
    repeat (4 * DEPTH + 4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("final_model_empty", 32'(sb.size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
